uart_tx_buffered: RTL and testbench
===================================

// Module: uart_tx_buffered
// PURPOSE
//  Buffered 8N1 UART transmitter; the transmit end of the Tang Nano host UART link.
//  Bytes are accepted on a valid/ready handshake into a 16-deep FIFO.
//  They are serialised LSB-first on tx with 1 start bit and 1 stop bit, with no idle gap between frames.
//  Bit timing matches the uart_rx framing, so a loopback of tx to rx must round-trip cleanly.
// PARAMETERS
//  SYSCLOCK   27.0  system clock frequency, MHz (real)
//  BAUDRATE   1.0   line rate, Mbit/s (real)
//  FIFO_DEPTH 16    byte FIFO entries; must be a power of 2, >= 2
//  Derived: CLKPERBIT = int'(SYSCLOCK/BAUDRATE), which is 27 at defaults; must be >= 2
// PORTS
//  clk            in   1  system clock
//  rst            in   1  synchronous reset, active-high
//  data_in        in   8  byte to transmit
//  data_in_valid  in   1  data_in is valid this cycle
//  data_in_ready  out  1  FIFO can accept; a byte transfers when valid && ready at a clk edge
//  tx             out  1  serial line, registered, idles high
//  tx_bsy         out  1  high while a frame is on the line (start bit through end of stop bit)
//  tx_done        out  1  one-cycle pulse on the last cycle of each stop bit
//  fifo_empty     out  1  FIFO holds no bytes
// BEHAVIOUR
//  Reset (sync, rst=1 at edge): outputs tx=1, tx_bsy=0, tx_done=0, fifo_empty=1, data_in_ready=0.
//   - FIFO pointers and count clear; bit counter, bit index and state clear; state=IDLE.
//   - data_in_ready rises the first cycle after rst deasserts.
//   - Reset asserted mid-frame aborts the frame: tx=1 on the next edge and the FIFO is flushed.
//  Handshake:
//   - data_in_ready = !full. It is registered from the FIFO count, so it drops the cycle after the 16th write.
//   - data_in is ignored when data_in_ready=0; no overwrite, no error flag.
//   - Push and pop in the same cycle are legal; the count stays unchanged. Pop-when-full frees a slot next cycle.
//  FSM: IDLE -> START -> DATA -> STOP -> (START | IDLE)
//   - IDLE:  tx=1. If !fifo_empty: pop the head into shift_reg and go to START.
//   - START: tx=0 for CLKPERBIT cycles.
//   - DATA:  tx=shift_reg[bit_idx] for CLKPERBIT cycles each, bit_idx 0..7; then STOP.
//   - STOP:  tx=1 for CLKPERBIT cycles. tx_done pulses on the final cycle.
//       - If the FIFO is non-empty on that final cycle: pop and go directly to START (zero gap).
//       - Otherwise go to IDLE.
//  Latency: a byte accepted at edge N into an empty FIFO while IDLE is popped at edge N+1.
//   - tx falls at edge N+2.
//  Frame length is exactly 10*CLKPERBIT cycles; back-to-back frames are contiguous.
//  Bit counter: width $clog2(CLKPERBIT); counts 0..CLKPERBIT-1, then wraps to 0 and advances the bit.
//  tx_bsy = (state != IDLE), registered alongside tx.
//  FIFO pointers: $clog2(FIFO_DEPTH) bits, wrap naturally. Count is $clog2(FIFO_DEPTH)+1 bits, 0..FIFO_DEPTH.
// STRUCTURE
//  uart_pkg: typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
//   - function clk_per_bit(real sysclk, real baud) shared with uart_rx;
//   - UART_DATA_BITS = 8.
//  Sub-module uart_tx_fifo (sync FIFO: wr_en, wr_data, rd_en, rd_data, full, empty).
//   - Show-ahead read: rd_data is valid whenever !empty.
//  Top-level holds the FSM, bit counter, shift_reg and output registers.
// TESTING (SYSCLOCK=27.0, BAUDRATE=1.0, CLKPERBIT=27)
//  1. Reset, then push 0x55 -> tx low at edge N+2 for 27 cycles, then bits 1,0,1,0,1,0,1,0 at 27 cycles each.
//     Then tx high 27 cycles; tx_done pulses once; tx_bsy is high for exactly 270 cycles.
//  2. Push 0xA3,0x00,0xFF in three consecutive cycles -> three contiguous 270-cycle frames with no idle cycle.
//     Loopback into uart_rx yields data_valid three times with data_out 0xA3, 0x00, 0xFF.
//  3. Hold valid=1 with 20 bytes 0x00..0x13 while the line is busy.
//     -> ready drops after 17 accepts (16 buffered + 1 in flight), reasserts after each pop.
//     -> all 20 bytes emerge in order, none lost or duplicated.
//  4. Assert rst for 1 cycle at cycle 100 of a frame with 5 bytes queued.
//     -> tx=1, tx_bsy=0, fifo_empty=1 the next cycle; no further frames start.
//  5. Push when FIFO full (ready=0) with data 0xEE -> 0xEE never appears on tx.
//  6. Push while the final STOP cycle pops -> push and pop coincide; count correct; next frame starts with no gap.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter states, data width and bit-period helper.
package uart_pkg;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    localparam int UART_DATA_BITS = 8;

    function automatic int clk_per_bit(input real sysclk, input real baud);
        return int'(sysclk / baud);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead byte FIFO; rd_data is the head whenever !empty.
// full is registered and held high through reset so writers stall until the FIFO is live.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             r_full;
    logic             w_wr;
    logic             w_rd;
    logic [PW:0]      w_count_nxt;

    assign w_wr        = wr_en && !r_full;
    assign w_rd        = rd_en && (r_count != '0);
    assign w_count_nxt = r_count + (PW+1)'(w_wr) - (PW+1)'(w_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b1;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (PW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= wr_data;
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign full    = r_full;
    assign empty   = (r_count == '0);

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: FIFO-fed, LSB first, back-to-back frames with no idle gap.
// A byte written into an empty FIFO while idle is popped one edge later; tx falls the edge after that.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter real SYSCLOCK   = 27.0,
    parameter real BAUDRATE   = 1.0,
    parameter int  FIFO_DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [UART_DATA_BITS-1:0] data_in,
    input  logic                      data_in_valid,
    output logic                      data_in_ready,
    output logic                      tx,
    output logic                      tx_bsy,
    output logic                      tx_done,
    output logic                      fifo_empty
);
    localparam int CLKPERBIT = clk_per_bit(SYSCLOCK, BAUDRATE);
    localparam int CNT_W     = $clog2(CLKPERBIT);
    localparam int IDX_W     = $clog2(UART_DATA_BITS);

    tx_state_t                 r_state;
    tx_state_t                 w_state_nxt;
    logic [CNT_W-1:0]          r_cnt;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic [CNT_W-1:0]          w_cnt_inc;
    logic [IDX_W-1:0]          r_idx;
    logic [IDX_W-1:0]          w_idx_nxt;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_tx;
    logic                      r_bsy;
    logic                      r_done;
    logic                      w_tx_nxt;
    logic                      w_last;
    logic                      w_pop;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic [UART_DATA_BITS-1:0] w_fifo_dat;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (data_in_valid && data_in_ready),
        .wr_data (data_in),
        .rd_en   (w_pop),
        .rd_data (w_fifo_dat),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    assign w_last    = (r_cnt == CNT_W'(CLKPERBIT - 1));
    assign w_cnt_inc = w_last ? '0 : r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_inc;
        w_idx_nxt   = r_idx;
        w_pop       = 1'b0;
        w_tx_nxt    = 1'b1;
        case (r_state)
            TX_IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = TX_START;
                end
            end
            TX_START: begin
                w_tx_nxt = 1'b0;
                if (w_last) w_state_nxt = TX_DATA;
            end
            TX_DATA: begin
                w_tx_nxt = r_shift[r_idx];
                if (w_last) begin
                    if (r_idx == IDX_W'(UART_DATA_BITS - 1)) w_state_nxt = TX_STOP;
                    else                                     w_idx_nxt   = r_idx + IDX_W'(1);
                end
            end
            TX_STOP: begin
                // Popping on the final stop cycle keeps consecutive frames contiguous.
                if (w_last) begin
                    w_idx_nxt = '0;
                    if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = TX_START;
                    end else begin
                        w_state_nxt = TX_IDLE;
                    end
                end
            end
            default: w_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= TX_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_bsy   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            if (w_pop) r_shift <= w_fifo_dat;
            r_tx    <= w_tx_nxt;
            r_bsy   <= (r_state != TX_IDLE);
            r_done  <= (r_state == TX_STOP) && w_last;
        end
    end

    assign data_in_ready = !w_fifo_full;
    assign fifo_empty    = w_fifo_empty;
    assign tx            = r_tx;
    assign tx_bsy        = r_bsy;
    assign tx_done       = r_done;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: table-driven single frames plus streaming, reset-abort and full-FIFO cases.
module tb_uart_tx_buffered;

    localparam int CPB = 27;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       tx;
    logic       tx_bsy;
    logic       tx_done;
    logic       fifo_empty;

    always #5 clk = ~clk;

    uart_tx_buffered #(
        .SYSCLOCK   (27.0),
        .BAUDRATE   (1.0),
        .FIFO_DEPTH (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .tx            (tx),
        .tx_bsy        (tx_bsy),
        .tx_done       (tx_done),
        .fifo_empty    (fifo_empty)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Scoreboard: accepted bytes in, decoded frames out.
    logic [7:0] exp_q[$];
    logic [9:0] got_q[$];
    int         exp_i = 0;
    int         got_i = 0;

    always @(posedge clk) begin
        if (!rst && data_in_valid && data_in_ready) exp_q.push_back(data_in);
    end

    // Line monitor: samples each bit at its centre, plus running activity counters.
    logic       mon_en = 1'b1;
    logic       m_active = 1'b0;
    int         m_cnt = 0;
    logic [9:0] m_frame = '0;
    int         bsy_hi = 0, bsy_rise = 0, done_hi = 0, tx_low = 0;
    logic       prev_bsy = 1'b0;

    always @(negedge clk) begin
        if (tx_bsy) bsy_hi++;
        if (tx_bsy && !prev_bsy) bsy_rise++;
        prev_bsy = tx_bsy;
        if (tx_done) done_hi++;
        if (!tx) tx_low++;
        if (!mon_en) begin
            m_active = 1'b0;
        end else begin
            if (!m_active && !tx) begin
                m_active = 1'b1;
                m_cnt    = 0;
                m_frame  = '0;
            end
            if (m_active) begin
                if (m_cnt % CPB == CPB / 2) m_frame[m_cnt / CPB] = tx;
                if (m_cnt == 9 * CPB + CPB / 2) begin
                    got_q.push_back(m_frame);
                    m_active = 1'b0;
                end
                m_cnt++;
            end
        end
    end

    task automatic sb_drain();
        while (got_i < got_q.size()) begin
            if (exp_i < exp_q.size()) begin
                check("sb_frame", got_q[got_i], {1'b1, exp_q[exp_i], 1'b0});
                exp_i++;
            end else begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_frame: got frame 0x%0h, want none", got_q[got_i]);
            end
            got_i++;
        end
        check("sb_missing", exp_q.size() - exp_i, 0);
    endtask

    task automatic drain(input int budget);
        int stable = 0;
        int t = 0;
        while (stable < 4 && t < budget) begin
            @(negedge clk);
            if (!tx_bsy && fifo_empty) stable++;
            else                       stable = 0;
            t++;
        end
        check("drain_in_budget", stable >= 4, 1);
        sb_drain();
    endtask

    // Holds valid with incrementing data until n bytes accepted; reports accepts before the first stall.
    task automatic stream(input int base, input int n, output int acc, output int first_drop);
        int   guard = 0;
        logic r;
        acc = 0;
        first_drop = -1;
        data_in_valid = 1'b1;
        while (acc < n && guard < 20000) begin
            data_in = 8'(base + acc);
            r = data_in_ready;
            @(negedge clk);
            if (r) acc++;
            else if (first_drop < 0) first_drop = acc;
            guard++;
        end
        data_in_valid = 1'b0;
    endtask

    typedef struct {
        logic [7:0] d;
        logic [9:0] frame;
        int         low_run;
    } vec_t;

    task automatic run_vec(input vec_t v);
        logic samp [0:269];
        logic [9:0] f;
        int run;
        int b0, d0;
        b0 = bsy_hi;
        d0 = done_hi;
        @(negedge clk);
        data_in = v.d;
        data_in_valid = 1'b1;
        check("vec_ready", data_in_ready, 1);
        @(negedge clk);
        data_in_valid = 1'b0;
        @(negedge clk);
        check("tx_high_before_start", tx, 1);
        @(negedge clk);
        check("tx_falls_at_n_plus_2", tx, 0);
        samp[0] = tx;
        for (int c = 1; c < 270; c++) begin
            @(negedge clk);
            samp[c] = tx;
        end
        f = '0;
        for (int k = 0; k < 10; k++) f[k] = samp[k * CPB + CPB / 2];
        run = 0;
        while (run < 270 && !samp[run]) run++;
        check("vec_frame", f, v.frame);
        check("vec_low_run", run, v.low_run);
        @(negedge clk);
        check("vec_bsy_end", tx_bsy, 0);
        repeat (2) @(negedge clk);
        check("vec_bsy_cycles", bsy_hi - b0, 270);
        check("vec_done_pulses", done_hi - d0, 1);
        sb_drain();
    endtask

    initial begin
        vec_t tbl[5];
        int acc, first_drop, b0, r0, d0, g0, l0, found, hi_rdy;

        tbl[0] = '{8'h55, 10'b1010101010, 27};
        tbl[1] = '{8'hA3, 10'b1101000110, 27};
        tbl[2] = '{8'h00, 10'b1000000000, 243};
        tbl[3] = '{8'hFF, 10'b1111111110, 27};
        tbl[4] = '{8'h80, 10'b1100000000, 216};

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_bsy", tx_bsy, 0);
        check("rst_done", tx_done, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_ready", data_in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", data_in_ready, 1);

        // Single frames
        foreach (tbl[i]) run_vec(tbl[i]);

        // Three consecutive pushes -> contiguous frames
        b0 = bsy_hi; r0 = bsy_rise; d0 = done_hi; g0 = got_q.size();
        data_in_valid = 1'b1;
        data_in = 8'hA3; @(negedge clk);
        data_in = 8'h00; @(negedge clk);
        data_in = 8'hFF; @(negedge clk);
        data_in_valid = 1'b0;
        drain(2000);
        check("b2b_bsy_cycles", bsy_hi - b0, 810);
        check("b2b_bsy_rises", bsy_rise - r0, 1);
        check("b2b_done_pulses", done_hi - d0, 3);
        check("b2b_frames", got_q.size() - g0, 3);

        // Streaming with backpressure
        r0 = bsy_rise; g0 = got_q.size();
        stream(0, 20, acc, first_drop);
        check("stream_accepts_before_stall", first_drop, 17);
        check("stream_all_accepted", acc, 20);
        drain(8000);
        check("stream_frames", got_q.size() - g0, 20);
        check("stream_bsy_rises", bsy_rise - r0, 1);

        // Reset mid-frame with bytes queued
        stream(8'h30, 6, acc, first_drop);
        l0 = 0;
        while (tx && l0 < 100) begin @(negedge clk); l0++; end
        check("abort_frame_started", tx, 0);
        repeat (99) @(negedge clk);
        mon_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_tx", tx, 1);
        check("abort_bsy", tx_bsy, 0);
        check("abort_empty", fifo_empty, 1);
        check("abort_ready_low", data_in_ready, 0);
        @(negedge clk);
        check("abort_ready_back", data_in_ready, 1);
        exp_i = exp_q.size();
        got_i = got_q.size();
        r0 = bsy_rise; l0 = tx_low;
        repeat (600) @(negedge clk);
        check("abort_no_new_frame", bsy_rise - r0, 0);
        check("abort_line_idle", tx_low - l0, 0);
        check("abort_still_empty", fifo_empty, 1);
        mon_en = 1'b1;

        // Full FIFO ignores writes
        g0 = got_q.size();
        stream(8'h40, 17, acc, first_drop);
        check("full_ready_low", data_in_ready, 0);
        data_in = 8'hEE;
        data_in_valid = 1'b1;
        hi_rdy = 0;
        repeat (20) begin
            if (data_in_ready) hi_rdy++;
            @(negedge clk);
        end
        data_in_valid = 1'b0;
        check("full_ready_stays_low", hi_rdy, 0);
        drain(7000);
        found = 0;
        for (int i = g0; i < got_q.size(); i++) if (got_q[i][8:1] == 8'hEE) found++;
        check("full_no_0xEE", found, 0);
        check("full_frames", got_q.size() - g0, 17);

        // Push coinciding with the final-stop-cycle pop
        b0 = bsy_hi; r0 = bsy_rise; d0 = done_hi;
        data_in_valid = 1'b1;
        data_in = 8'h61; @(negedge clk);
        data_in = 8'h62; @(negedge clk);
        data_in_valid = 1'b0;
        repeat (269) @(negedge clk);
        data_in = 8'h63;
        data_in_valid = 1'b1;
        check("coinc_ready", data_in_ready, 1);
        @(negedge clk);
        data_in_valid = 1'b0;
        check("coinc_done_now", tx_done, 1);
        check("coinc_not_empty", fifo_empty, 0);
        repeat (269) @(negedge clk);
        check("coinc_one_left", fifo_empty, 0);
        @(negedge clk);
        check("coinc_now_empty", fifo_empty, 1);
        drain(2000);
        check("coinc_bsy_cycles", bsy_hi - b0, 810);
        check("coinc_bsy_rises", bsy_rise - r0, 1);
        check("coinc_done_pulses", done_hi - d0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
